// File: rtl/violation_responder.sv
// Turns access-monitor violation strobes into a timed CPU reset pulse and keeps
// a sticky forensic record of the first offending access behind a 4-word register window.
module violation_responder #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned HOLDOFF_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        violation,
  input  logic [15:0] pc,
  input  logic        data_en,
  input  logic        code_en,
  input  logic        code_wr,
  input  logic [15:0] data_addr,
  input  logic [15:0] code_addr,
  input  logic        per_en,
  input  logic        per_we,
  input  logic [1:0]  per_addr,
  input  logic [15:0] per_din,
  output logic [15:0] per_dout,
  output logic        cpu_rst,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;

  localparam logic [7:0] RST_LOAD  = 8'(RST_CYCLES);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [2:0]  flags_q, flags_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] daddr_q, daddr_d;
  logic [15:0] caddr_q, caddr_d;
  logic [7:0]  vcount_q, vcount_d;
  logic [15:0] per_dout_q, per_dout_d;

  logic accept;
  logic stat_wr;
  logic clr_valid;
  logic clr_cnt;
  logic capture;
  logic unused_din;

  assign unused_din = ^per_din[15:2];

  // The last HOLDOFF cycle behaves like IDLE so a still-high violation re-arms without a gap.
  assign accept    = violation &&
                     ((state_q == IDLE) || ((state_q == HOLDOFF) && (cnt_q == 8'd1)));
  assign stat_wr   = per_en && per_we && (per_addr == 2'd0);
  assign clr_valid = stat_wr && per_din[0];
  assign clr_cnt   = stat_wr && per_din[1];
  assign capture   = accept && (!valid_q || clr_valid);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cpu_rst_d = cpu_rst_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
      end
      ASSERT: begin
        if (cnt_q == 8'd1) begin
          state_d   = HOLDOFF;
          cnt_d     = HOLD_LOAD;
          cpu_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLDOFF: begin
        if (cnt_q == 8'd1) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        cpu_rst_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
    if (accept) begin
      state_d   = ASSERT;
      cnt_d     = RST_LOAD;
      cpu_rst_d = 1'b1;
      busy_d    = 1'b1;
    end
  end

  // A concurrent accept overrides a software clear of valid or of the counter.
  always_comb begin
    valid_d  = valid_q;
    flags_d  = flags_q;
    pc_d     = pc_q;
    daddr_d  = daddr_q;
    caddr_d  = caddr_q;
    vcount_d = vcount_q;
    if (clr_valid) valid_d = 1'b0;
    if (accept)    valid_d = 1'b1;
    if (capture) begin
      flags_d = {code_wr, code_en, data_en};
      pc_d    = pc;
      daddr_d = data_addr;
      caddr_d = code_addr;
    end
    if (clr_cnt) begin
      vcount_d = {7'd0, accept};
    end else if (accept && (vcount_q != 8'hFF)) begin
      vcount_d = vcount_q + 8'd1;
    end
  end

  always_comb begin
    per_dout_d = 16'h0000;
    if (per_en && !per_we) begin
      case (per_addr)
        2'd0:    per_dout_d = {vcount_q, 4'b0000, flags_q, valid_q};
        2'd1:    per_dout_d = pc_q;
        2'd2:    per_dout_d = daddr_q;
        default: per_dout_d = caddr_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      cpu_rst_q  <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      flags_q    <= 3'd0;
      pc_q       <= 16'h0000;
      daddr_q    <= 16'h0000;
      caddr_q    <= 16'h0000;
      vcount_q   <= 8'd0;
      per_dout_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      flags_q    <= flags_d;
      pc_q       <= pc_d;
      daddr_q    <= daddr_d;
      caddr_q    <= caddr_d;
      vcount_q   <= vcount_d;
      per_dout_q <= per_dout_d;
    end
  end

  assign per_dout = per_dout_q;
  assign cpu_rst  = cpu_rst_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_violation_responder.sv
// Self-checking bench for violation_responder: directed scenarios plus random traffic,
// all compared against a time-window reference model of the reset pulse and register file.
module tb_violation_responder;

  localparam int R = 16;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        violation;
  logic [15:0] pc;
  logic        data_en;
  logic        code_en;
  logic        code_wr;
  logic [15:0] data_addr;
  logic [15:0] code_addr;
  logic        per_en;
  logic        per_we;
  logic [1:0]  per_addr;
  logic [15:0] per_din;
  logic [15:0] per_dout;
  logic        cpu_rst;
  logic        busy;

  int totalChecks = 0;
  int badChecks   = 0;

  // Reference model: the reset pulse is a window of edges after the last accept.
  int          edgeCnt = 0;
  int          mLastAcc;
  int          mVcount;
  logic        mValid;
  logic [2:0]  mFlags;
  logic [15:0] mPc;
  logic [15:0] mDaddr;
  logic [15:0] mCaddr;
  logic [15:0] mDout;

  violation_responder #(.RST_CYCLES(R), .HOLDOFF_CYCLES(H)) dut (
    .clk(clk), .reset_n(reset_n), .violation(violation), .pc(pc),
    .data_en(data_en), .code_en(code_en), .code_wr(code_wr),
    .data_addr(data_addr), .code_addr(code_addr), .per_en(per_en),
    .per_we(per_we), .per_addr(per_addr), .per_din(per_din),
    .per_dout(per_dout), .cpu_rst(cpu_rst), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at edge %0d", tag, obs, exp, edgeCnt);
    end
  endtask

  task automatic modelReset();
    mLastAcc = -1000;
    mVcount  = 0;
    mValid   = 1'b0;
    mFlags   = 3'd0;
    mPc      = 16'h0;
    mDaddr   = 16'h0;
    mCaddr   = 16'h0;
    mDout    = 16'h0;
  endtask

  function automatic logic [15:0] modelRead(input logic [1:0] a);
    logic [7:0] vc;
    vc = 8'(mVcount);
    case (a)
      2'd0:    return {vc, 4'b0000, mFlags, mValid};
      2'd1:    return mPc;
      2'd2:    return mDaddr;
      default: return mCaddr;
    endcase
  endfunction

  task automatic modelEdge();
    bit acc;
    bit wr;
    edgeCnt++;
    acc   = violation && (edgeCnt >= mLastAcc + R + H);
    mDout = (per_en && !per_we) ? modelRead(per_addr) : 16'h0;
    wr    = per_en && per_we && (per_addr == 2'd0);
    if (wr && per_din[0]) mValid = 1'b0;
    if (wr && per_din[1]) mVcount = 0;
    if (acc) begin
      mLastAcc = edgeCnt;
      if (mVcount < 255) mVcount++;
      if (!mValid) begin
        mFlags = {code_wr, code_en, data_en};
        mPc    = pc;
        mDaddr = data_addr;
        mCaddr = code_addr;
      end
      mValid = 1'b1;
    end
  endtask

  task automatic stepCycle();
    logic expRst;
    logic expBusy;
    @(posedge clk);
    modelEdge();
    #1;
    expRst  = (edgeCnt >= mLastAcc) && (edgeCnt < mLastAcc + R);
    expBusy = (edgeCnt >= mLastAcc) && (edgeCnt < mLastAcc + R + H);
    checkOutput("cpu_rst", {31'd0, cpu_rst}, {31'd0, expRst});
    checkOutput("busy", {31'd0, busy}, {31'd0, expBusy});
    checkOutput("per_dout", {16'd0, per_dout}, {16'd0, mDout});
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] p, input logic [2:0] f,
                               input logic [15:0] da, input logic [15:0] ca);
    violation = v;
    pc        = p;
    code_wr   = f[2];
    code_en   = f[1];
    data_en   = f[0];
    data_addr = da;
    code_addr = ca;
  endtask

  task automatic readReg(input logic [1:0] a, output logic [15:0] v);
    per_en = 1'b1; per_we = 1'b0; per_addr = a;
    stepCycle();
    v = per_dout;
    per_en = 1'b0;
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [15:0] d);
    per_en = 1'b1; per_we = 1'b1; per_addr = a; per_din = d;
    stepCycle();
    per_en = 1'b0; per_we = 1'b0; per_din = 16'h0;
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] v;
    int rstCnt;
    int busyCnt;
    int pulses;
    logic prev;

    reset_n = 1'b0;
    per_en = 1'b0; per_we = 1'b0; per_addr = 2'd0; per_din = 16'h0;
    applyStimulus(1'b0, 16'h0, 3'd0, 16'h0, 16'h0);
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_dout", {16'd0, per_dout}, 32'd0);
    reset_n = 1'b1;

    // Basic response
    applyStimulus(1'b1, 16'hA010, 3'b001, 16'h0600, 16'h0000);
    stepCycle();
    violation = 1'b0;
    rstCnt = int'(cpu_rst); busyCnt = int'(busy);
    repeat (29) begin
      stepCycle();
      rstCnt += int'(cpu_rst); busyCnt += int'(busy);
    end
    checkOutput("basic_rst_len", rstCnt, 16);
    checkOutput("basic_busy_len", busyCnt, 20);
    readReg(2'd0, v); checkOutput("basic_status", {16'd0, v}, 32'h0103);
    readReg(2'd1, v); checkOutput("basic_pc", {16'd0, v}, 32'hA010);
    readReg(2'd2, v); checkOutput("basic_daddr", {16'd0, v}, 32'h0600);

    // Sticky record
    applyStimulus(1'b1, 16'hB000, 3'b001, 16'h0700, 16'h0000);
    stepCycle();
    violation = 1'b0;
    repeat (25) stepCycle();
    readReg(2'd1, v); checkOutput("sticky_pc", {16'd0, v}, 32'hA010);
    readReg(2'd0, v); checkOutput("sticky_status", {16'd0, v}, 32'h0203);
    writeReg(2'd0, 16'h0001);
    readReg(2'd0, v); checkOutput("sticky_cleared", {16'd0, v}, 32'h0202);

    // Ignore window
    writeReg(2'd0, 16'h0002);
    pulses = 0; prev = cpu_rst;
    violation = 1'b1;
    for (int i = 0; i < 45; i++) begin
      if (i == 20) violation = 1'b0;
      stepCycle();
      if (cpu_rst && !prev) pulses++;
      prev = cpu_rst;
    end
    checkOutput("ignore_pulses", pulses, 1);
    readReg(2'd0, v); checkOutput("ignore_vcount", {24'd0, v[15:8]}, 32'd1);

    // Simultaneous accept and STATUS clear
    applyStimulus(1'b1, 16'hD00D, 3'b011, 16'h1234, 16'h5678);
    per_en = 1'b1; per_we = 1'b1; per_addr = 2'd0; per_din = 16'h0003;
    stepCycle();
    per_en = 1'b0; per_we = 1'b0; per_din = 16'h0; violation = 1'b0;
    repeat (22) stepCycle();
    readReg(2'd0, v);
    checkOutput("simul_valid", {31'd0, v[0]}, 32'd1);
    checkOutput("simul_vcount", {24'd0, v[15:8]}, 32'd1);
    readReg(2'd3, v); checkOutput("simul_caddr", {16'd0, v}, 32'h5678);

    // Async reset during ASSERT
    applyStimulus(1'b1, 16'hC000, 3'b110, 16'h0000, 16'hF00C);
    stepCycle();
    violation = 1'b0;
    repeat (4) stepCycle();
    reset_n = 1'b0;
    #2;
    checkOutput("async_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    checkOutput("async_busy", {31'd0, busy}, 32'd0);
    modelReset();
    #1;
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      readReg(2'(a), v);
      checkOutput("async_reg_zero", {16'd0, v}, 32'd0);
    end
    applyStimulus(1'b1, 16'h0100, 3'b001, 16'h0200, 16'h0300);
    stepCycle();
    violation = 1'b0;
    rstCnt = int'(cpu_rst);
    repeat (25) begin
      stepCycle();
      rstCnt += int'(cpu_rst);
    end
    checkOutput("async_new_pulse", rstCnt, 16);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 7) == 0), 16'($urandom), 3'($urandom),
                    16'($urandom), 16'($urandom));
      per_en   = ($urandom_range(0, 2) == 0);
      per_we   = ($urandom_range(0, 3) == 0);
      per_addr = 2'($urandom);
      per_din  = 16'($urandom);
      stepCycle();
    end
    per_en = 1'b0; per_we = 1'b0; violation = 1'b0;
    repeat (25) stepCycle();

    // Saturation: violation held high re-arms every R+H cycles
    writeReg(2'd0, 16'h0002);
    violation = 1'b1;
    repeat (6100) stepCycle();
    violation = 1'b0;
    repeat (25) stepCycle();
    readReg(2'd0, v); checkOutput("sat_vcount", {24'd0, v[15:8]}, 32'd255);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/violation_responder.md
# violation_responder

Consumes the violation strobe produced by the protected-module access monitor and turns it into a controlled CPU reset sequence, while capturing a forensic record of the first offending access. It sits between the monitor's `reset` output and the openMSP430 core reset input. It exposes a small peripheral-style register window so trusted software can read and clear the record after reboot.

## Interface

Parameters:

- `RST_CYCLES`, default 16: number of cycles `cpu_rst` is held high per accepted violation. Legal range 1..255.
- `HOLDOFF_CYCLES`, default 4: number of cycles after reset release during which violations are ignored. Legal range 1..255.

Ports:

- `clk`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `violation`  in  1  level from the monitor; sampled each cycle.
- `pc`  in  16  program counter at the violating cycle.
- `data_en`  in  1  data-bus enable at the violating cycle.
- `code_en`  in  1  code-bus enable at the violating cycle.
- `code_wr`  in  1  code-bus write at the violating cycle.
- `data_addr`  in  16  data-bus address at the violating cycle.
- `code_addr`  in  16  code-bus address at the violating cycle.
- `per_en`  in  1  register access strobe.
- `per_we`  in  1  1 = write, 0 = read; qualified by `per_en`.
- `per_addr`  in  2  register select.
- `per_din`  in  16  write data.
- `per_dout`  out  16  read data; 0 when no read is pending (OR-bus compatible).
- `cpu_rst`  out  1  active-high reset to the core.
- `busy`  out  1  high in ASSERT and HOLDOFF.

## Operation

FSM states and transitions:

- **IDLE**: if `violation`=1, accept it and go to ASSERT.
- **ASSERT**: `cpu_rst`=1. An 8-bit down-counter is loaded with `RST_CYCLES`. When it expires, reload it with `HOLDOFF_CYCLES` and go to HOLDOFF.
- **HOLDOFF**: `cpu_rst`=0. When the counter expires, go to IDLE.
- `violation` is ignored in ASSERT and HOLDOFF: no record update, no count.

Accept actions:

- The counter `vcount` (8 bits) increments and saturates at 255.
- If `valid`=0, latch `pc`, `data_addr`, `code_addr`, and `flags`={`code_wr`,`code_en`,`data_en`}, then set `valid`=1.
- If `valid`=1, the record is left unchanged. The first violation is sticky.

Registers, selected by `per_addr`:

- 0 STATUS: [0] `valid`, [3:1] `flags`, [7:4] 0, [15:8] `vcount`.
  - Write: bit0=1 clears `valid`; bit1=1 clears `vcount`. Other bits are ignored.
- 1 PC (read only).
- 2 DATA_ADDR (read only).
- 3 CODE_ADDR (read only).
- Writes to addresses 1-3 have no effect.

Simultaneous events:

- Accept and valid-clear in the same cycle: the accept wins. The record is captured and `valid`=1.
- Accept and count-clear in the same cycle: `vcount`=1.
- Clearing `valid` does not erase the latched PC/ADDR/flags. Those values persist until the next capture.

## Timing

- Reset (`reset_n`=0, async): state=IDLE; `cpu_rst`=0, `busy`=0, `per_dout`=0, `valid`=0, `vcount`=0, and all record registers 0.
- `violation` sampled high at edge N in IDLE:
  - `cpu_rst`=1 and `busy`=1 from edge N through edge N+`RST_CYCLES`, i.e. exactly `RST_CYCLES` cycles.
  - `busy` stays 1 for `HOLDOFF_CYCLES` further cycles.
  - The FSM is in IDLE, and can accept again, at edge N+`RST_CYCLES`+`HOLDOFF_CYCLES`.
- Record and `vcount` update at edge N, so they are visible to a read issued at edge N+1.
- Register read latency is one cycle:
  - `per_en`=1, `per_we`=0 at edge M gives data on `per_dout` after edge M. It is valid for one cycle, then returns to 0.
- Register writes take effect at the sampling edge.
- `reset_n` asserted mid-ASSERT: `cpu_rst` drops to 0 immediately, without waiting for a clock, and the FSM returns to IDLE.

## Test plan

- **Basic response:** reset, then pulse `violation` for 1 cycle with pc=16'hA010, data_addr=16'h0600, data_en=1. Required: `cpu_rst` high for exactly 16 cycles; `busy` high for 20 cycles; STATUS read = 16'h0103; PC=16'hA010; DATA_ADDR=16'h0600.
- **Sticky record:** two violations, the second at pc=16'hB000 arriving after HOLDOFF. Required: PC stays 16'hA010 and `vcount`=2. Then write STATUS=16'h0001. Required: STATUS=16'h0202, with flags retained and `valid` cleared.
- **Ignore window:** hold `violation`=1 continuously for 20 cycles. Required: exactly one reset pulse and `vcount`=1. A second pulse starts only if `violation` is still high at IDLE re-entry (cycle 20).
- **Simultaneous:** accept a violation in the same cycle as writing STATUS=16'h0003. Required: `valid`=1 and `vcount`=1.
- **Saturation:** force 300 accepted violations. Required: `vcount`=255.
- **Async reset:** drop `reset_n` at cycle 5 of ASSERT. Required: `cpu_rst`=0 before the next edge and all registers read 0. A new violation afterwards produces a full 16-cycle pulse.
